// File: rtl/ysyx_24080014_wbu.sv
// ysyx_24080014_wbu: write-back unit with a one-entry holding register,
// the architectural register file and the retirement counter.
// Optional feature macro: WBU_BYPASS_EN -- forwards the held, not yet
// retired write onto the read ports in the same cycle.
module ysyx_24080014_wbu #(
    parameter int NR_REG = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_pc,
    input  logic [4:0]  wb_rd,
    input  logic        wb_wen,
    input  logic [31:0] wb_wdata,
    input  logic        commit_stall,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic [31:0] instret
);

    localparam int         IW     = (NR_REG > 1) ? $clog2(NR_REG) : 1;
    localparam logic [5:0] NR_LIM = 6'(NR_REG);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        hold_valid;
    logic [31:0] hold_pc;
    logic [4:0]  hold_rd;
    logic        hold_wen;
    logic [31:0] hold_wdata;

    logic        accept;
    logic        retire;
    logic        wr_en;
    logic [31:0] last_pc;

    logic [31:0] regs [NR_REG];

    // Index 0 and indices beyond the implemented file are not real registers.
    function automatic logic in_range(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < NR_LIM);
    endfunction

    // Read path: out-of-range and x0 read as zero; optional forwarding of the held write.
    function automatic logic [31:0] rf_read(input logic [4:0] idx);
        if (!in_range(idx)) begin
            return '0;
        end
`ifdef WBU_BYPASS_EN
        if (hold_valid && hold_wen && (hold_rd == idx)) begin
            return hold_wdata;
        end
`endif
        return regs[idx[IW-1:0]];
    endfunction

    assign hold_valid = (state == FULL);

    // Handshake, retirement and next-state decode.
    always_comb begin
        state_nxt    = state;
        wb_ready     = !hold_valid || !commit_stall;
        accept       = wb_valid && wb_ready;
        retire       = hold_valid && !commit_stall;
        commit_valid = retire;
        wr_en        = retire && hold_wen && in_range(hold_rd);
        commit_pc    = retire ? hold_pc : last_pc;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            FULL:  if (retire && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Holding register captures the incoming result on every accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_pc    <= '0;
            hold_rd    <= '0;
            hold_wen   <= 1'b0;
            hold_wdata <= '0;
        end else if (accept) begin
            hold_pc    <= wb_pc;
            hold_rd    <= wb_rd;
            hold_wen   <= wb_wen;
            hold_wdata <= wb_wdata;
        end
    end

    // Retirement bookkeeping: last committed PC and the retired-instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pc <= '0;
            instret <= '0;
        end else if (retire) begin
            last_pc <= hold_pc;
            instret <= instret + 32'd1;
        end
    end

    // Register file write on retirement of a writing instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: '0};
        end else if (wr_en) begin
            regs[hold_rd[IW-1:0]] <= hold_wdata;
        end
    end

    // Combinational read ports.
    always_comb begin
        rs1_data = rf_read(rs1_addr);
        rs2_data = rf_read(rs2_addr);
    end

endmodule

// File: tb/tb_ysyx_24080014_wbu.sv
// Self-checking bench for ysyx_24080014_wbu: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_ysyx_24080014_wbu;

    localparam int NR = 16;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [31:0] wb_wdata;
    logic        commit_stall;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] instret;

    ysyx_24080014_wbu #(.NR_REG(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_pc        (wb_pc),
        .wb_rd        (wb_rd),
        .wb_wen       (wb_wen),
        .wb_wdata     (wb_wdata),
        .commit_stall (commit_stall),
        .rs1_addr     (rs1_addr),
        .rs1_data     (rs1_data),
        .rs2_addr     (rs2_addr),
        .rs2_data     (rs2_data),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] wdata;
    } entry_t;

    // Reference model state
    entry_t      hq[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_instret;
    logic [31:0] m_last_pc;

    int n_cmp;
    int n_fail;

    localparam bit BYP =
`ifdef WBU_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        hq.delete();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_instret = '0;
        m_last_pc = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0 || int'(a) >= NR) return '0;
        if (BYP && hq.size() != 0 && hq[0].wen && hq[0].rd == a) return hq[0].wdata;
        return m_regs[a];
    endfunction

    task automatic check_cycle();
        logic        hv;
        logic        e_ready;
        logic        e_cv;
        logic [31:0] e_cpc;
        hv      = (hq.size() != 0);
        e_ready = !hv || !commit_stall;
        e_cv    = hv && !commit_stall;
        e_cpc   = m_last_pc;
        if (e_cv) e_cpc = hq[0].pc;
        cmp("wb_ready", {31'b0, wb_ready}, {31'b0, e_ready});
        cmp("commit_valid", {31'b0, commit_valid}, {31'b0, e_cv});
        cmp("commit_pc", commit_pc, e_cpc);
        cmp("instret", instret, m_instret);
        cmp("rs1_data", rs1_data, m_read(rs1_addr));
        cmp("rs2_data", rs2_data, m_read(rs2_addr));
    endtask

    // Effect of the coming rising edge on the model.
    task automatic model_edge();
        logic   hv;
        logic   ret;
        logic   acc;
        entry_t e;
        if (!rst) begin
            model_clear();
            return;
        end
        hv  = (hq.size() != 0);
        ret = hv && !commit_stall;
        acc = wb_valid && (!hv || !commit_stall);
        if (ret) begin
            e = hq.pop_front();
            if (e.wen && e.rd != 5'd0 && int'(e.rd) < NR) m_regs[e.rd] = e.wdata;
            m_instret = m_instret + 32'd1;
            m_last_pc = e.pc;
        end
        if (acc) begin
            e.pc = wb_pc; e.rd = wb_rd; e.wen = wb_wen; e.wdata = wb_wdata;
            hq.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic wen, input logic [31:0] wd, input logic st);
        wb_valid = v; wb_pc = pc; wb_rd = rd; wb_wen = wen; wb_wdata = wd; commit_stall = st;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        model_clear();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] pc;
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b0;
        model_clear();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        #2;
        // reset state
        cmp("rst_ready", {31'b0, wb_ready}, 32'd1);
        cmp("rst_commit_valid", {31'b0, commit_valid}, 32'd0);
        cmp("rst_instret", instret, 32'd0);
        cmp("rst_commit_pc", commit_pc, 32'd0);
        cmp("rst_rs1", rs1_data, 32'd0);
        @(posedge clk); #1;
        step();
        rst = 1'b1;

        // basic write and latency
        drive(1'b1, 32'h8000_0000, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0);
        #1 cmp("ready_after_reset", {31'b0, wb_ready}, 32'd1);
        step();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        #1 cmp("t1_commit_valid", {31'b0, commit_valid}, 32'd1);
        cmp("t1_commit_pc", commit_pc, 32'h8000_0000);
        step();
        #1 cmp("t1_rs1", rs1_data, 32'hDEAD_BEEF);
        cmp("t1_instret", instret, 32'd1);

        // write to x0 retires but is discarded
        drive(1'b1, 32'h8000_0004, 5'd0, 1'b1, 32'h1234_5678, 1'b0);
        rs1_addr = 5'd0;
        step();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        #1 cmp("x0_commit_valid", {31'b0, commit_valid}, 32'd1);
        cmp("x0_rs1", rs1_data, 32'd0);
        step();
        #1 cmp("x0_instret", instret, 32'd2);
        cmp("x0_rs1_after", rs1_data, 32'd0);

        // three-cycle stall with a pending input
        drive(1'b1, 32'h100, 5'd9, 1'b1, 32'h1111, 1'b0);
        rs1_addr = 5'd9;
        step();
        drive(1'b1, 32'h104, 5'd10, 1'b1, 32'h2222, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 cmp("stall_ready", {31'b0, wb_ready}, 32'd0);
            cmp("stall_commit_valid", {31'b0, commit_valid}, 32'd0);
            cmp("stall_commit_pc", commit_pc, 32'h8000_0004);
            cmp("stall_rs1", rs1_data, BYP ? 32'h1111 : 32'd0);
            step();
        end
        commit_stall = 1'b0;
        #1 cmp("release_commit_valid", {31'b0, commit_valid}, 32'd1);
        cmp("release_ready", {31'b0, wb_ready}, 32'd1);
        cmp("release_commit_pc", commit_pc, 32'h100);
        step();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        #1 cmp("release_next_valid", {31'b0, commit_valid}, 32'd1);
        cmp("release_next_pc", commit_pc, 32'h104);
        cmp("release_rs1", rs1_data, 32'h1111);
        step();
        rs1_addr = 5'd10;
        #1 cmp("release_idle", {31'b0, commit_valid}, 32'd0);
        cmp("release_instret", instret, 32'd4);
        cmp("release_rs1_x10", rs1_data, 32'h2222);

        // back-to-back throughput
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 5'(i + 1), 1'b1, 32'(32'hC0 + i), 1'b0);
            #1;
            if (i > 0) begin
                cmp("b2b_valid", {31'b0, commit_valid}, 32'd1);
                cmp("b2b_pc", commit_pc, 32'(4 * (i - 1)));
            end
            step();
        end
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        #1 cmp("b2b_valid_last", {31'b0, commit_valid}, 32'd1);
        cmp("b2b_pc_last", commit_pc, 32'hC);
        step();
        #1 cmp("b2b_idle", {31'b0, commit_valid}, 32'd0);
        cmp("b2b_instret", instret, 32'd4);

        // pending write visibility on port 2
        drive(1'b1, 32'h200, 5'd3, 1'b1, 32'h3333_3333, 1'b0);
        step();
        drive(1'b1, 32'h204, 5'd3, 1'b1, 32'hA5A5_A5A5, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        rs2_addr = 5'd3;
        #1 cmp("byp_rs2", rs2_data, BYP ? 32'hA5A5_A5A5 : 32'h3333_3333);
        step();
        #1 cmp("byp_rs2_hold", rs2_data, BYP ? 32'hA5A5_A5A5 : 32'h3333_3333);
        commit_stall = 1'b0;
        step();
        #1 cmp("byp_rs2_written", rs2_data, 32'hA5A5_A5A5);

        // reset while holding an entry
        drive(1'b1, 32'h300, 5'd7, 1'b1, 32'h77, 1'b0);
        rs1_addr = 5'd7;
        step();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        #2;
        rst = 1'b0;
        model_clear();
        #1 cmp("midrst_commit_valid", {31'b0, commit_valid}, 32'd0);
        cmp("midrst_instret", instret, 32'd0);
        cmp("midrst_rs1", rs1_data, 32'd0);
        step();
        rst = 1'b1;
        commit_stall = 1'b0;
        #1 cmp("midrst_ready", {31'b0, wb_ready}, 32'd1);
        cmp("midrst_valid_after", {31'b0, commit_valid}, 32'd0);
        step();
        #1 cmp("midrst_x7", rs1_data, 32'd0);

        // randomized traffic
        pc = 32'h8000_0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                model_clear();
                step();
                rst = 1'b1;
            end else begin
                pc = pc + 32'd4;
                drive($urandom_range(0, 3) != 0, pc, 5'($urandom_range(0, 31)),
                      $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0);
                rs1_addr = $urandom_range(0, 1) ? wb_rd : 5'($urandom_range(0, 31));
                rs2_addr = (hq.size() != 0 && $urandom_range(0, 1)) ? hq[0].rd
                                                                    : 5'($urandom_range(0, 31));
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24080014_wbu.md
YSYX_24080014_WBU -- requirements
Module: ysyx_24080014_wbu

Interface
REQ-001 NR_REG, 32, number of architectural registers; 16 selects RV32E.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 wb_valid  input  1  memory stage result valid.
REQ-005 wb_ready  output  1  WBU accepts the result this cycle.
REQ-006 wb_pc  input  32  PC of the incoming instruction.
REQ-007 wb_rd  input  5  destination register index.
REQ-008 wb_wen  input  1  instruction writes wb_rd.
REQ-009 wb_wdata  input  32  write-back value, already sign/zero-extended by the memory stage.
REQ-010 commit_stall  input  1  hold retirement, for debug halt or difftest back-pressure.
REQ-011 rs1_addr  input  5  read port 1 index.
REQ-012 rs1_data  output  32  read port 1 data, combinational.
REQ-013 rs2_addr  input  5  read port 2 index.
REQ-014 rs2_data  output  32  read port 2 data, combinational.
REQ-015 commit_valid  output  1  one instruction retires this cycle.
REQ-016 commit_pc  output  32  PC of the retiring instruction.
REQ-017 instret  output  32  count of retired instructions.

Function
REQ-018 The WBU SHALL contain a register file of NR_REG x 32 bits and a one-entry holding register {hold_valid, pc, rd, wen, wdata}.
REQ-019 States SHALL be EMPTY (hold_valid=0) and FULL (hold_valid=1).
REQ-020 wb_ready SHALL be the combinational term !hold_valid || !commit_stall.
REQ-021 An accept SHALL occur when wb_valid && wb_ready, and the holding register SHALL capture the inputs at that edge.
REQ-022 In FULL with commit_stall=0, commit_valid SHALL be 1 and commit_pc SHALL equal the held pc. At the following edge, the register file SHALL be written if held wen=1 and rd!=0 and rd<NR_REG, and instret SHALL increment.
REQ-023 Transitions:
- EMPTY + accept -> FULL.
- FULL + retire + accept -> FULL, with the new entry and no bubble.
- FULL + retire + no accept -> EMPTY.
- FULL + commit_stall -> FULL, held unchanged, commit_valid=0.
REQ-024 Latency SHALL be: accept at edge N, commit_valid high in cycle N+1, register file updated at edge N+1. Sustained throughput SHALL be 1 instruction per cycle.
REQ-025 Reads of index 0 or index >= NR_REG SHALL return 0. Writes to those indices SHALL be discarded, but the instruction still retires.
REQ-026 instret SHALL wrap from 0xFFFFFFFF to 0x00000000.
REQ-027 commit_valid SHALL be 0 whenever state is EMPTY. commit_pc SHALL hold its last value when commit_valid=0.

Reset
REQ-028 While rst=0, all register file entries, hold_valid, the held fields, commit_pc and instret SHALL clear to 0, regardless of clk.
REQ-029 A reset asserted while FULL SHALL discard the held entry: no register write and no commit.
REQ-030 After rst deasserts, wb_ready SHALL be 1 in the first cycle.

Configuration
REQ-031 With WBU_BYPASS_EN defined, a pending write SHALL be visible on rsN_data in the same cycle. Pending means state FULL, held wen=1, held rd=rsN_addr, rd!=0 and rd<NR_REG; the held wdata is returned. This applies even while commit_stall=1.
REQ-032 Without WBU_BYPASS_EN, rsN_data SHALL come from the register file array only, so the new value appears the cycle after the write edge.

Verification
REQ-033 Reset, then accept {pc=0x80000000, rd=5, wen=1, wdata=0xDEADBEEF}, then read rs1_addr=5:
- next cycle: commit_valid=1, commit_pc=0x80000000;
- following cycle: rs1_data=0xDEADBEEF, instret=1.
REQ-034 Accept rd=0, wen=1, wdata=0x12345678 -> rs1_addr=0 reads 0; commit_valid=1; instret increments.
REQ-035 Assert commit_stall for 3 cycles with an entry held and wb_valid=1:
- wb_ready=0 and commit_valid=0 for 3 cycles, register unchanged;
- the cycle after the stall releases: commit_valid=1 and the next entry is accepted in that same cycle.
REQ-036 Drive 4 back-to-back accepts (pc 0x0/0x4/0x8/0xC) -> commit_valid high on 4 consecutive cycles, instret=4.
REQ-037 With WBU_BYPASS_EN, hold {rd=3, wdata=0xA5A5A5A5} with commit_stall=1 and set rs2_addr=3 -> rs2_data=0xA5A5A5A5. Without WBU_BYPASS_EN, rs2_data keeps the old value.
REQ-038 Assert rst mid-FULL with rd=7 -> x7 reads 0, commit_valid=0, instret=0; wb_ready=1 after release.
